hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that sequences the stall and flush inputs of the fetch/decode and decode/execute pipeline registers. It detects load-use hazards, holds the front of the pipeline while a multi-cycle execute operation (mul/div) completes, and squashes wrong-path instructions after a branch misprediction. It sits beside the decode stage and drives its `stall`/`flush` inputs plus the fetch register's equivalents.

## Interface

Parameters:
- `REG_COUNT`, 32, architectural register count.
- `REG_BITS`, `$clog2(REG_COUNT)`, register index width.
- `BR_PENALTY`, 2, flush cycles after a misprediction (>=1).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous active-high reset.
- `dec_rs1`, `dec_rs2`  in  REG_BITS  source indices of the instruction in decode.
- `dec_use_rs1`, `dec_use_rs2`  in  1  corresponding source is actually read.
- `exc_valid`  in  1  execute stage holds a real instruction.
- `exc_mem_read`  in  1  execute instruction is a load.
- `exc_rd`  in  REG_BITS  execute destination index.
- `br_resolve`  in  1  branch resolved in execute this cycle.
- `br_taken`  in  1  resolved direction.
- `br_pred`  in  1  predicted direction carried down the pipeline.
- `mc_start`  in  1  execute holds a multi-cycle op, first cycle.
- `mc_done`  in  1  multi-cycle unit result ready.
- `stall_fetch`  out  1  hold PC and fetch/decode register.
- `stall_dec`  out  1  hold decode/execute register.
- `flush_fetch`  out  1  zero fetch/decode register.
- `flush_dec`  out  1  zero decode/execute register (bubble).
- `redirect`  out  1  one-cycle pulse: fetch takes execute-computed target.
- `busy`  out  1  state is not RUN.

## Operation

- States: RUN, MC_WAIT, FLUSH. Flush counter `fcnt` is `$clog2(BR_PENALTY+1)` bits.
- Mispredict: `br_resolve & (br_taken != br_pred)`.
- Load-use: `exc_valid & exc_mem_read & exc_rd != 0 & ((dec_use_rs1 & dec_rs1 == exc_rd) | (dec_use_rs2 & dec_rs2 == exc_rd))`.
- In RUN, priority is mispredict, then `mc_start`, then load-use.
  - Mispredict: `redirect=1`, `flush_fetch=1`, `flush_dec=1`. If BR_PENALTY>1, go to FLUSH with `fcnt=BR_PENALTY-1`.
  - `mc_start`: `stall_fetch=1`, `stall_dec=1`, go to MC_WAIT. If `mc_done` is also high, stay in RUN with no stall.
  - Load-use: `stall_fetch=1`, `flush_dec=1`, `stall_dec=0`. This inserts a single bubble. No state change, because the next cycle's compare clears naturally.
- MC_WAIT: `stall_fetch=1`, `stall_dec=1` every cycle.
  - On `mc_done`, outputs drop in that same cycle and the state returns to RUN.
  - Load-use and `br_resolve` are ignored in this state.
- FLUSH: `flush_fetch=1`, `flush_dec=1`, `fcnt` decrements. When `fcnt==1`, return to RUN. All other inputs are ignored.
- Invariant: `stall_dec & flush_dec` is never 1. Decode ignores flush while stalled.
- `busy = (state != RUN)`.

## Timing

- Outputs are Mealy: a combinational function of the registered state plus current inputs. Detection adds zero latency.
- State and counters update on `posedge clk`.
- While `rst=1`, all outputs are forced to 0. The next edge sets state=RUN, `fcnt=0` and the perf counters to 0.
- Reset asserted mid-MC_WAIT or mid-FLUSH abandons the sequence. Outputs are 0 from that cycle.
- A misprediction costs BR_PENALTY cycles of flush. A load-use costs exactly 1 cycle. A multi-cycle op costs the cycles from `mc_start` to `mc_done` inclusive, minus one.

## Configuration

- `HAZARD_PERF_EN` defined: adds outputs `perf_stall_cycles` and `perf_flush_events`, each 32 bits.
  - `perf_stall_cycles` increments in every cycle with `stall_fetch=1`.
  - `perf_flush_events` increments on each mispredict detection.
  - Both wrap at 2^32 and reset to 0.
- `HAZARD_PERF_EN` undefined: neither port nor logic exists. Hazard behaviour is identical either way.

## Structure

- Shared `pipeline_pkg` holds:
  - `hz_state_t` enum {RUN, MC_WAIT, FLUSH}.
  - The default `REG_COUNT`.
  - The `REG_BITS` constant.
- Sub-module `hazard_perf_cnt` holds the two counters. It is instantiated only under `HAZARD_PERF_EN`.

## Test plan

- Load-use: `exc_mem_read=1`, `exc_rd=5`, `dec_rs1=5`, `dec_use_rs1=1` -> one cycle of `stall_fetch=1`, `flush_dec=1`, `stall_dec=0`. Repeat with `exc_rd=0` -> no stall.
- Mispredict with BR_PENALTY=2: `br_resolve=1`, `br_taken=1`, `br_pred=0` -> `redirect` high for 1 cycle, `flush_fetch`/`flush_dec` high for 2 cycles, `busy` high for 1 cycle, then RUN.
- Multi-cycle: `mc_start` at cycle 0, `mc_done` at cycle 4 -> `stall_fetch`/`stall_dec` high cycles 0-3, low at cycle 4. A load-use match at cycle 2 causes no `flush_dec`.
- Simultaneous: mispredict, `mc_start` and load-use all in the same cycle -> flush path only, state FLUSH, no MC_WAIT.
- Reset mid-FLUSH: assert `rst` one cycle after a mispredict -> all outputs 0 that cycle, state RUN afterwards. With `HAZARD_PERF_EN`, the counters read 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM states and register-file sizing.
// Optional HAZARD_PERF_EN adds performance counters to hazard_ctrl.
package pipeline_pkg;

  localparam int DEF_REG_COUNT = 32;
  localparam int DEF_REG_BITS  = $clog2(DEF_REG_COUNT);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall-cycle and mispredict-event counters for the hazard controller.
// Instantiated only when HAZARD_PERF_EN is defined.
module hazard_perf_cnt
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush_event,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_event)
        flush_events <= flush_events + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, mul/div holds, mispredict flush.
// Define HAZARD_PERF_EN to add perf_stall_cycles / perf_flush_events outputs.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_COUNT  = DEF_REG_COUNT,
  parameter int REG_BITS   = $clog2(REG_COUNT),
  parameter int BR_PENALTY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] dec_rs1,
  input  logic [REG_BITS-1:0] dec_rs2,
  input  logic                dec_use_rs1,
  input  logic                dec_use_rs2,
  input  logic                exc_valid,
  input  logic                exc_mem_read,
  input  logic [REG_BITS-1:0] exc_rd,
  input  logic                br_resolve,
  input  logic                br_taken,
  input  logic                br_pred,
  input  logic                mc_start,
  input  logic                mc_done,
  output logic                stall_fetch,
  output logic                stall_dec,
  output logic                flush_fetch,
  output logic                flush_dec,
  output logic                redirect,
  output logic                busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_flush_events
`endif
);

  localparam int FW = $clog2(BR_PENALTY + 1);

  hz_state_t       state_q, state_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            mispredict;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            load_use;

  assign mispredict = br_resolve & (br_taken != br_pred);
  assign rs1_hit    = dec_use_rs1 & (dec_rs1 == exc_rd);
  assign rs2_hit    = dec_use_rs2 & (dec_rs2 == exc_rd);
  assign load_use   = exc_valid & exc_mem_read
                    & (exc_rd != '0) & (rs1_hit | rs2_hit);

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_fetch = 1'b0;
    stall_dec   = 1'b0;
    flush_fetch = 1'b0;
    flush_dec   = 1'b0;
    redirect    = 1'b0;
    busy        = 1'b0;
    // Outputs stay quiet through reset so no stage acts on stale state.
    if (!rst) begin
      busy = (state_q != RUN);
      unique case (state_q)
        RUN: begin
          if (mispredict) begin
            redirect    = 1'b1;
            flush_fetch = 1'b1;
            flush_dec   = 1'b1;
            if (BR_PENALTY > 1) begin
              state_d = FLUSH;
              fcnt_d  = FW'(BR_PENALTY - 1);
            end
          end else if (mc_start) begin
            if (!mc_done) begin
              stall_fetch = 1'b1;
              stall_dec   = 1'b1;
              state_d     = MC_WAIT;
            end
          end else if (load_use) begin
            stall_fetch = 1'b1;
            flush_dec   = 1'b1;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            state_d = RUN;
          end else begin
            stall_fetch = 1'b1;
            stall_dec   = 1'b1;
          end
        end
        FLUSH: begin
          flush_fetch = 1'b1;
          flush_dec   = 1'b1;
          fcnt_d      = fcnt_q - FW'(1);
          if (fcnt_q == FW'(1))
            state_d = RUN;
        end
        default: begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall_fetch),
    .flush_event  (redirect),
    .stall_cycles (perf_stall_cycles),
    .flush_events (perf_flush_events)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic
// compared against a cycle-budget reference model.
module tb_hazard_ctrl;

  localparam int RB = 5;
  localparam int BP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [RB-1:0] dec_rs1, dec_rs2, exc_rd;
  logic          dec_use_rs1, dec_use_rs2;
  logic          exc_valid, exc_mem_read;
  logic          br_resolve, br_taken, br_pred;
  logic          mc_start, mc_done;
  logic          stall_fetch, stall_dec, flush_fetch;
  logic          flush_dec, redirect, busy;
`ifdef HAZARD_PERF_EN
  logic [31:0]   perf_stall_cycles, perf_flush_events;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_COUNT  (32),
    .REG_BITS   (RB),
    .BR_PENALTY (BP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_use_rs1  (dec_use_rs1),
    .dec_use_rs2  (dec_use_rs2),
    .exc_valid    (exc_valid),
    .exc_mem_read (exc_mem_read),
    .exc_rd       (exc_rd),
    .br_resolve   (br_resolve),
    .br_taken     (br_taken),
    .br_pred      (br_pred),
    .mc_start     (mc_start),
    .mc_done      (mc_done),
    .stall_fetch  (stall_fetch),
    .stall_dec    (stall_dec),
    .flush_fetch  (flush_fetch),
    .flush_dec    (flush_dec),
    .redirect     (redirect),
    .busy         (busy)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_events (perf_flush_events)
`endif
  );

  int tests  = 0;
  int failed = 0;

  // Reference model: remaining flush cycles and an outstanding mul/div flag.
  int          m_flush_left = 0;
  bit          m_mc_busy    = 1'b0;
  bit          m_cnt_known  = 1'b0;
  logic [31:0] m_stall_cnt  = '0;
  logic [31:0] m_flush_cnt  = '0;

  logic s_sf, s_sd, s_ff, s_fd, s_rd, s_busy;

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    dec_rs1 = '0; dec_rs2 = '0; exc_rd = '0;
    dec_use_rs1 = 0; dec_use_rs2 = 0;
    exc_valid = 0; exc_mem_read = 0;
    br_resolve = 0; br_taken = 0; br_pred = 0;
    mc_start = 0; mc_done = 0;
  endtask

  task automatic step();
    bit mp, lu;
    bit e_sf, e_sd, e_ff, e_fd, e_rd, e_busy;
    @(negedge clk);
    mp = br_resolve && (br_taken != br_pred);
    lu = exc_valid && exc_mem_read && (exc_rd != 0) &&
         ((dec_use_rs1 && dec_rs1 == exc_rd) ||
          (dec_use_rs2 && dec_rs2 == exc_rd));
    {e_sf, e_sd, e_ff, e_fd, e_rd, e_busy} = '0;
    if (rst) begin
    end else if (m_flush_left > 0) begin
      e_ff = 1; e_fd = 1; e_busy = 1;
    end else if (m_mc_busy) begin
      e_busy = 1;
      if (!mc_done) begin e_sf = 1; e_sd = 1; end
    end else if (mp) begin
      e_rd = 1; e_ff = 1; e_fd = 1;
    end else if (mc_start) begin
      if (!mc_done) begin e_sf = 1; e_sd = 1; end
    end else if (lu) begin
      e_sf = 1; e_fd = 1;
    end
    s_sf = stall_fetch; s_sd = stall_dec; s_ff = flush_fetch;
    s_fd = flush_dec;   s_rd = redirect;  s_busy = busy;
    check("stall_fetch", s_sf, e_sf);
    check("stall_dec",   s_sd, e_sd);
    check("flush_fetch", s_ff, e_ff);
    check("flush_dec",   s_fd, e_fd);
    check("redirect",    s_rd, e_rd);
    check("busy",        s_busy, e_busy);
    check("stall_and_flush_dec", s_sd & s_fd, 1'b0);
`ifdef HAZARD_PERF_EN
    if (m_cnt_known) begin
      check32("perf_stall_cycles", perf_stall_cycles, m_stall_cnt);
      check32("perf_flush_events", perf_flush_events, m_flush_cnt);
    end
`endif
    if (rst) begin
      m_flush_left = 0;
      m_mc_busy    = 0;
      m_stall_cnt  = '0;
      m_flush_cnt  = '0;
      m_cnt_known  = 1;
    end else begin
      if (m_flush_left > 0)
        m_flush_left--;
      else if (m_mc_busy) begin
        if (mc_done) m_mc_busy = 0;
      end else if (mp)
        m_flush_left = BP - 1;
      else if (mc_start && !mc_done)
        m_mc_busy = 1;
      m_stall_cnt += 32'(e_sf);
      m_flush_cnt += 32'(e_rd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;

    // Reset
    step();
    step();
    rst = 0;
    step();
    check("idle_busy", s_busy, 1'b0);

    // Load-use on rs1
    exc_valid = 1; exc_mem_read = 1; exc_rd = 5'd5;
    dec_rs1 = 5'd5; dec_use_rs1 = 1;
    step();
    check("lu_stall_fetch", s_sf, 1'b1);
    check("lu_flush_dec",   s_fd, 1'b1);
    check("lu_stall_dec",   s_sd, 1'b0);
    exc_mem_read = 0;
    step();
    check("lu_clears", s_sf, 1'b0);

    // x0 destination never stalls
    exc_mem_read = 1; exc_rd = '0; dec_rs1 = '0;
    step();
    check("lu_x0_nostall", s_sf, 1'b0);
    idle_inputs();

    // Mispredict
    br_resolve = 1; br_taken = 1; br_pred = 0;
    step();
    check("mp_redirect", s_rd, 1'b1);
    check("mp_busy0",    s_busy, 1'b0);
    idle_inputs();
    step();
    check("mp_flush2",    s_ff, 1'b1);
    check("mp_redirect2", s_rd, 1'b0);
    check("mp_busy1",     s_busy, 1'b1);
    step();
    check("mp_done_flush", s_ff, 1'b0);
    check("mp_done_busy",  s_busy, 1'b0);

    // Multi-cycle op, load-use match at cycle 2 is ignored
    mc_start = 1;
    step();
    check("mc_c0_stall", s_sd, 1'b1);
    mc_start = 0;
    step();
    exc_valid = 1; exc_mem_read = 1; exc_rd = 5'd7;
    dec_rs2 = 5'd7; dec_use_rs2 = 1;
    step();
    check("mc_c2_no_flush", s_fd, 1'b0);
    check("mc_c2_stall",    s_sf, 1'b1);
    idle_inputs();
    step();
    mc_done = 1;
    step();
    check("mc_c4_release", s_sf, 1'b0);
    mc_done = 0;
    step();
    check("mc_after_busy", s_busy, 1'b0);

    // mc_start with mc_done in the same cycle
    mc_start = 1; mc_done = 1;
    step();
    check("mc_same_cycle", s_sf, 1'b0);
    idle_inputs();
    step();

    // Simultaneous mispredict, mc_start and load-use
    br_resolve = 1; br_taken = 0; br_pred = 1; mc_start = 1;
    exc_valid = 1; exc_mem_read = 1; exc_rd = 5'd3;
    dec_rs1 = 5'd3; dec_use_rs1 = 1;
    step();
    check("sim_redirect", s_rd, 1'b1);
    check("sim_no_stall", s_sd, 1'b0);
    idle_inputs();
    step();
    check("sim_flush_state", s_busy, 1'b1);
    check("sim_no_mc",       s_sf, 1'b0);
    step();

    // Reset one cycle after a mispredict
    br_resolve = 1; br_taken = 1; br_pred = 0;
    step();
    idle_inputs();
    rst = 1;
    step();
    check("rst_flush_zero", s_ff, 1'b0);
    rst = 0;
    step();
    check("rst_run", s_busy, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      dec_rs1      = RB'($urandom_range(0, 3));
      dec_rs2      = RB'($urandom_range(0, 3));
      exc_rd       = RB'($urandom_range(0, 3));
      dec_use_rs1  = $urandom_range(0, 1) == 1;
      dec_use_rs2  = $urandom_range(0, 1) == 1;
      exc_valid    = $urandom_range(0, 3) != 0;
      exc_mem_read = $urandom_range(0, 2) == 0;
      br_resolve   = $urandom_range(0, 7) == 0;
      br_taken     = $urandom_range(0, 1) == 1;
      br_pred      = $urandom_range(0, 1) == 1;
      mc_start     = $urandom_range(0, 9) == 0;
      mc_done      = $urandom_range(0, 3) == 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
